// File: rtl/mda_adc_scan_sequencer_if.sv
// ADC controller handshake bundle: start strobe and channel select out,
// done level and conversion result back.
interface mda_adc_scan_sequencer_if;
    logic        adc_start;
    logic [2:0]  adc_ch;
    logic        adc_done;
    logic [11:0] adc_data;

    modport master (output adc_start, adc_ch, input adc_done, adc_data);
    modport slave  (input adc_start, adc_ch, output adc_done, adc_data);
endinterface

// File: rtl/mda_adc_scan_sequencer.sv
// ADC scan sequencer: walks the set bits of a latched channel mask in
// ascending order, runs one conversion per channel on the ADC controller and
// keeps the latest sample per channel with a fresh flag.
// Optional feature: define MDA_ADC_SEQ_TIMEOUT_EN to abandon conversions that
// stay in WAIT for TIMEOUT_CYCLES clocks and raise a sticky timeout_err.
module mda_adc_scan_sequencer #(
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            ch_mask,
    input  logic [7:0]            fresh_clr,
    input  logic                  err_clr,
    mda_adc_scan_sequencer_if.master adc,
    output logic [7:0][11:0]      ch_data,
    output logic [7:0]            ch_fresh,
    output logic                  result_valid,
    output logic [2:0]            result_ch,
    output logic [11:0]           result_data,
    output logic                  scan_done,
    output logic                  busy,
    output logic                  timeout_err
);
    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, STORE, GAP} state_t;

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  scan_mask;
    logic [2:0]  cur_ch, new_ch;
    logic        load_ch;
    logic [11:0] cap_data;
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;
    logic        timed_out_q;
    logic [2:0]  first_ch, nxt_ch;
    logic        first_vld, nxt_vld;
    logic        done_hit, tmo_hit;
    logic [7:0]  fresh_set;

    assign done_hit = (state_q == WAIT) && adc.adc_done;

`ifdef MDA_ADC_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    // wait_cnt is 0 in the first WAIT cycle, so this fires at the end of WAIT cycle TIMEOUT_CYCLES
    assign tmo_hit = (state_q == WAIT) && !adc.adc_done && (wait_cnt >= TMO_LAST);

    // sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= (timeout_err & ~err_clr) | tmo_hit;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // lowest set bit of the incoming mask picks the first channel of a scan
    always_comb begin
        first_ch  = '0;
        first_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch  = 3'(i);
                first_vld = 1'b1;
            end
        end
    end

    // next higher set bit of the latched mask; no wrap within a scan
    always_comb begin
        nxt_ch  = '0;
        nxt_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (scan_mask[i] && (3'(i) > cur_ch)) begin
                nxt_ch  = 3'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state and control decode
    always_comb begin
        state_d   = state_q;
        load_ch   = 1'b0;
        new_ch    = cur_ch;
        scan_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && first_vld) begin
                    state_d = START;
                    load_ch = 1'b1;
                    new_ch  = first_ch;
                end
            end
            START: state_d = ARM;
            // adc_done is still the previous conversion's level here
            ARM:   state_d = WAIT;
            WAIT: begin
                if (done_hit || tmo_hit) state_d = STORE;
            end
            STORE: begin
                // a dropped enable lets the current conversion land, then stops quietly
                if (!enable) begin
                    state_d = IDLE;
                end else if (nxt_vld) begin
                    state_d = START;
                    load_ch = 1'b1;
                    new_ch  = nxt_ch;
                end else begin
                    scan_done = 1'b1;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc.adc_start = (state_q == START);
    assign adc.adc_ch    = cur_ch;
    assign busy          = (state_q != IDLE);
    // a timed-out conversion passes through STORE only to reuse its sequencing
    assign result_valid  = (state_q == STORE) && !timed_out_q;
    assign result_ch     = cur_ch;
    assign result_data   = cap_data;
    assign fresh_set     = result_valid ? (8'd1 << cur_ch) : 8'd0;

    // datapath: mask/channel latching, sample capture, counters, fresh flags
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_mask   <= '0;
            cur_ch      <= '0;
            cap_data    <= '0;
            ch_data     <= '0;
            ch_fresh    <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == START) scan_mask <= ch_mask;
            if (load_ch) cur_ch <= new_ch;
            if (done_hit) begin
                cap_data        <= adc.adc_data;
                ch_data[cur_ch] <= adc.adc_data;
            end
            if (state_q != WAIT)          wait_cnt <= '0;
            else if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            if (state_q != GAP) gap_cnt <= '0;
            else                gap_cnt <= gap_cnt + 16'd1;
            if (state_q == WAIT) timed_out_q <= tmo_hit;
            // set wins over a same-cycle clear
            ch_fresh <= (ch_fresh & ~fresh_clr) | fresh_set;
        end
    end
endmodule

// File: tb/tb_mda_adc_scan_sequencer.sv
module tb_mda_adc_scan_sequencer;
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [7:0]      ch_mask = '0;
    logic [7:0]      fresh_clr = '0;
    logic            err_clr = 1'b0;
    logic [7:0][11:0] ch_data;
    logic [7:0]      ch_fresh;
    logic            result_valid;
    logic [2:0]      result_ch;
    logic [11:0]     result_data;
    logic            scan_done;
    logic            busy;
    logic            timeout_err;

    mda_adc_scan_sequencer_if bus();

    mda_adc_scan_sequencer #(.GAP_CYCLES(10), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .fresh_clr(fresh_clr), .err_clr(err_clr), .adc(bus),
        .ch_data(ch_data), .ch_fresh(ch_fresh), .result_valid(result_valid),
        .result_ch(result_ch), .result_data(result_data), .scan_done(scan_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rd = 0;
    logic [14:0] exp_q[$];

    // ADC controller model: done drops on a start edge (or one clock later
    // in stale mode), rises lat clocks after the start with 12'h100+ch+data_ofs
    int          lat = 4;
    bit          stale_mode = 1'b0;
    bit          hang_en = 1'b0;
    logic [2:0]  hang_ch = '0;
    logic [11:0] data_ofs = '0;
    logic        start_q;
    int          m_cnt;
    logic [2:0]  m_ch;
    logic        m_stale;

    always @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0; m_cnt <= 0; m_ch <= '0; m_stale <= 1'b0;
            bus.adc_done <= 1'b0; bus.adc_data <= '0;
        end else begin
            start_q <= bus.adc_start;
            if (bus.adc_start && !start_q) begin
                m_ch    <= bus.adc_ch;
                m_cnt   <= lat;
                m_stale <= stale_mode;
                if (!stale_mode) bus.adc_done <= 1'b0;
            end else begin
                if (m_stale) begin
                    bus.adc_done <= 1'b0;
                    m_stale      <= 1'b0;
                end
                if (m_cnt > 0) begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1 && !(hang_en && m_ch == hang_ch)) begin
                        bus.adc_done <= 1'b1;
                        bus.adc_data <= 12'h100 + 12'(m_ch) + data_ofs;
                    end
                end
            end
        end
    end

    // monitor: records starts, scan_done pulses and results with cycle stamps
    int          cyc = 0;
    int          n_st = 0, n_res = 0, n_done = 0, done_cyc = 0;
    logic [2:0]  st_ch[0:255];
    int          st_cyc[0:255];
    logic [14:0] res_arr[0:255];
    int          res_cyc[0:255];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.adc_start) begin
            st_ch[n_st[7:0]]  <= bus.adc_ch;
            st_cyc[n_st[7:0]] <= cyc;
            n_st <= n_st + 1;
        end
        if (!reset && scan_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (!reset && result_valid) begin
            res_arr[n_res[7:0]] <= {result_ch, result_data};
            res_cyc[n_res[7:0]] <= cyc;
            n_res <= n_res + 1;
        end
    end

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; ch_mask = '0; fresh_clr = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.adc_start, bus.adc_ch, result_valid, result_ch, result_data, scan_done, busy, timeout_err} !== 21'd0) begin
            errors++;
            $display("FAIL reset_ctl got start=%b ch=%0d rv=%b rch=%0d rdata=%h done=%b busy=%b terr=%b want all 0",
                     bus.adc_start, bus.adc_ch, result_valid, result_ch, result_data, scan_done, busy, timeout_err);
        end
        checks++;
        if (ch_data !== 96'd0) begin errors++; $display("FAIL reset_ch_data got=%h want=0", ch_data); end
        checks++;
        if (ch_fresh !== 8'd0) begin errors++; $display("FAIL reset_ch_fresh got=%h want=0", ch_fresh); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_disabled_busy got=%b want=0", busy); end
    endtask

    task automatic test_full_scan();
        logic [7:0][11:0] exp_cd;
        logic [14:0] e;
        int d0;
        d0 = n_done; lat = 4; data_ofs = '0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({3'(i), 12'h100 + 12'(i)});
            exp_cd[i] = 12'h100 + 12'(i);
        end
        ch_mask = 8'hFF; enable = 1'b1;
        for (int k = 0; k < 500 && scan_done !== 1'b1; k++) @(negedge clk);
        checks++;
        if (scan_done !== 1'b1) begin errors++; $display("FAIL full_scan_done got=%b want=1", scan_done); end
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got=%b want=0", busy); end
        checks++;
        if (n_done !== d0 + 1) begin errors++; $display("FAIL full_done_count got=%0d want=%0d", n_done - d0, 1); end
        checks++;
        if (ch_data !== exp_cd) begin errors++; $display("FAIL full_ch_data got=%h want=%h", ch_data, exp_cd); end
        checks++;
        if (ch_fresh !== 8'hFF) begin errors++; $display("FAIL full_ch_fresh got=%h want=ff", ch_fresh); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL full_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        checks++;
        if (n_res !== rd) begin errors++; $display("FAIL full_result_count got=%0d want=%0d", n_res, rd); end
        rd = n_res;
    endtask

    task automatic test_sparse_gap();
        logic [14:0] e;
        int d0, s0;
        fresh_clr = 8'hFF; @(negedge clk); fresh_clr = '0;
        d0 = n_done; s0 = n_st; lat = 4; data_ofs = 12'h020;
        exp_q.push_back({3'd0, 12'h120});
        exp_q.push_back({3'd2, 12'h122});
        exp_q.push_back({3'd7, 12'h127});
        exp_q.push_back({3'd0, 12'h120});
        ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int k = 0; k < 300 && n_st < s0 + 4; k++) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if ({st_ch[s0[7:0]], st_ch[8'(s0 + 1)], st_ch[8'(s0 + 2)], st_ch[8'(s0 + 3)]} !== {3'd0, 3'd2, 3'd7, 3'd0}) begin
            errors++;
            $display("FAIL sparse_start_chs got=%0d,%0d,%0d,%0d want=0,2,7,0", st_ch[s0[7:0]],
                     st_ch[8'(s0 + 1)], st_ch[8'(s0 + 2)], st_ch[8'(s0 + 3)]);
        end
        checks++;
        if (n_st !== s0 + 4) begin errors++; $display("FAIL sparse_start_count got=%0d want=4", n_st - s0); end
        checks++;
        if (st_cyc[8'(s0 + 3)] - done_cyc < 11) begin
            errors++; $display("FAIL sparse_gap got=%0d clocks want>=11", st_cyc[8'(s0 + 3)] - done_cyc);
        end
        checks++;
        if (n_done !== d0 + 1) begin errors++; $display("FAIL sparse_done_count got=%0d want=1", n_done - d0); end
        checks++;
        if (ch_data[7] !== 12'h127 || ch_data[1] !== 12'h101) begin
            errors++; $display("FAIL sparse_ch_data got ch7=%h ch1=%h want ch7=127 ch1=101", ch_data[7], ch_data[1]);
        end
        checks++;
        if (ch_fresh !== 8'b1000_0101) begin errors++; $display("FAIL sparse_ch_fresh got=%h want=85", ch_fresh); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL sparse_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        checks++;
        if (n_res !== rd) begin errors++; $display("FAIL sparse_result_count got=%0d want=%0d", n_res, rd); end
        rd = n_res;
    endtask

    task automatic test_stale_done();
        logic [14:0] e;
        int s0, r0;
        s0 = n_st; r0 = n_res; lat = 400; stale_mode = 1'b1; data_ofs = 12'h033;
        exp_q.push_back({3'd0, 12'h133});
        ch_mask = 8'h01; enable = 1'b1;
        for (int k = 0; k < 20 && n_st == s0; k++) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 600 && result_valid !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < 50 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (n_res !== r0 + 1 || res_cyc[r0[7:0]] - st_cyc[s0[7:0]] < 400) begin
            errors++; $display("FAIL stale_latency got=%0d clocks (results=%0d) want>=400 (1)",
                               res_cyc[r0[7:0]] - st_cyc[s0[7:0]], n_res - r0);
        end
        checks++;
        if (ch_data[0] !== 12'h133) begin errors++; $display("FAIL stale_ch_data got=%h want=133", ch_data[0]); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL stale_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        rd = n_res; stale_mode = 1'b0; lat = 4;
    endtask

    task automatic test_enable_drop();
        logic [14:0] e;
        int s0, d0;
        fresh_clr = 8'hFF; @(negedge clk); fresh_clr = '0;
        s0 = n_st; d0 = n_done; lat = 20; data_ofs = 12'h040;
        for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), 12'h140 + 12'(i)});
        ch_mask = 8'hFF; enable = 1'b1;
        for (int k = 0; k < 300 && n_st < s0 + 4; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (n_st !== s0 + 4) begin errors++; $display("FAIL drop_start_count got=%0d want=4", n_st - s0); end
        checks++;
        if (n_done !== d0) begin errors++; $display("FAIL drop_scan_done got=%0d want=0", n_done - d0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b want=0", busy); end
        checks++;
        if (ch_data[3] !== 12'h143) begin errors++; $display("FAIL drop_ch3_data got=%h want=143", ch_data[3]); end
        checks++;
        if (ch_fresh !== 8'h0F) begin errors++; $display("FAIL drop_ch_fresh got=%h want=0f", ch_fresh); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL drop_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        checks++;
        if (n_res !== rd) begin errors++; $display("FAIL drop_result_count got=%0d want=%0d", n_res, rd); end
        rd = n_res; lat = 4;
    endtask

    task automatic test_fresh_collision();
        logic [14:0] e;
        fresh_clr = 8'hFF; @(negedge clk); fresh_clr = '0;
        data_ofs = 12'h050;
        exp_q.push_back({3'd5, 12'h155});
        ch_mask = 8'h20; enable = 1'b1;
        for (int k = 0; k < 100 && result_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL fresh_store_seen got=%b want=1", result_valid); end
        fresh_clr = 8'h20;
        @(negedge clk);
        fresh_clr = '0; enable = 1'b0;
        checks++;
        if (ch_fresh[5] !== 1'b1) begin errors++; $display("FAIL fresh_collision got=%b want=1", ch_fresh[5]); end
        fresh_clr = 8'h20;
        @(negedge clk);
        fresh_clr = '0;
        checks++;
        if (ch_fresh[5] !== 1'b0) begin errors++; $display("FAIL fresh_clear got=%b want=0", ch_fresh[5]); end
        for (int k = 0; k < 50 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL fresh_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        rd = n_res;
    endtask

`ifdef MDA_ADC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [14:0] e;
        int s0, d0;
        fresh_clr = 8'hFF; @(negedge clk); fresh_clr = '0;
        s0 = n_st; d0 = n_done; lat = 5; data_ofs = 12'h060;
        hang_en = 1'b1; hang_ch = 3'd1;
        exp_q.push_back({3'd0, 12'h160});
        exp_q.push_back({3'd2, 12'h162});
        ch_mask = 8'h07; enable = 1'b1;
        for (int k = 0; k < 500 && scan_done !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set got=%b want=1", timeout_err); end
        checks++;
        if (ch_fresh !== 8'b0000_0101) begin errors++; $display("FAIL tmo_ch_fresh got=%h want=05", ch_fresh); end
        checks++;
        if (ch_data[1] !== 12'h141) begin errors++; $display("FAIL tmo_ch1_data got=%h want=141", ch_data[1]); end
        checks++;
        if (n_st !== s0 + 3 || st_ch[8'(s0 + 2)] !== 3'd2) begin
            errors++; $display("FAIL tmo_continue got starts=%0d last_ch=%0d want starts=3 last_ch=2", n_st - s0, st_ch[8'(s0 + 2)]);
        end
        checks++;
        if (st_cyc[8'(s0 + 2)] - st_cyc[8'(s0 + 1)] !== 53) begin
            errors++; $display("FAIL tmo_duration got=%0d want=53", st_cyc[8'(s0 + 2)] - st_cyc[8'(s0 + 1)]);
        end
        checks++;
        if (n_done !== d0 + 1) begin errors++; $display("FAIL tmo_scan_done got=%0d want=1", n_done - d0); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL tmo_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        checks++;
        if (n_res !== rd) begin errors++; $display("FAIL tmo_result_count got=%0d want=%0d", n_res, rd); end
        rd = n_res;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clr got=%b want=0", timeout_err); end
        hang_en = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0][11:0] exp_cd;
        logic [14:0] e;
        lat = 5; hang_en = 1'b1; hang_ch = 3'd1;
        ch_mask = 8'h02; enable = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.adc_ch !== 3'd1) begin
            errors++; $display("FAIL mid_waiting got busy=%b ch=%0d want busy=1 ch=1", busy, bus.adc_ch);
        end
`ifndef MDA_ADC_SEQ_TIMEOUT_EN
        err_clr = 1'b1;
        repeat (200) @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL no_timeout got busy=%b terr=%b want busy=1 terr=0", busy, timeout_err);
        end
`endif
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, bus.adc_start, bus.adc_ch, timeout_err, ch_fresh} !== 14'd0 || ch_data !== 96'd0) begin
            errors++; $display("FAIL mid_reset got busy=%b start=%b ch=%0d terr=%b fresh=%h data=%h want all 0",
                               busy, bus.adc_start, bus.adc_ch, timeout_err, ch_fresh, ch_data);
        end
        reset = 1'b0; hang_en = 1'b0; lat = 4; data_ofs = 12'h070;
        @(negedge clk);
        exp_cd = '0; exp_cd[3] = 12'h173;
        exp_q.push_back({3'd3, 12'h173});
        ch_mask = 8'h08; enable = 1'b1;
        for (int k = 0; k < 50 && result_valid !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 50 && busy !== 1'b0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (ch_data !== exp_cd) begin errors++; $display("FAIL post_reset_data got=%h want=%h", ch_data, exp_cd); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= n_res || res_arr[rd[7:0]] !== e) begin
                errors++; $display("FAIL post_reset_result[%0d] got=%h want=%h", rd, res_arr[rd[7:0]], e);
            end
            rd++;
        end
        rd = n_res;
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_gap();
        test_stale_done();
        test_enable_drop();
        test_fresh_collision();
`ifdef MDA_ADC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end
endmodule

// File: doc/mda_adc_scan_sequencer.md
MDA_ADC_SCAN_SEQUENCER -- requirements
Module: mda_adc_scan_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0: idle clocks inserted after each completed scan (0..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: clocks in WAIT before a conversion is abandoned (1..65535).
REQ-003 clk  in  1  single clock for all logic, max 40 MHz, same clock as the ADC controller.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  level; 1 = scan continuously.
REQ-006 ch_mask  in  8  bit i = 1 includes channel i in the scan.
REQ-007 fresh_clr  in  8  bit i = 1 clears ch_fresh[i] for one cycle.
REQ-008 err_clr  in  1  clears timeout_err.
REQ-009 adc_start  out  1  start strobe to the ADC controller; rising edge triggers a conversion.
REQ-010 adc_ch  out  3  channel select to the ADC controller.
REQ-011 adc_done  in  1  ADC controller done level; stays high until the next start.
REQ-012 adc_data  in  12  ADC controller result; valid while adc_done = 1.
REQ-013 ch_data  out  96  packed results; channel i occupies bits [12i+11:12i].
REQ-014 ch_fresh  out  8  bit i = 1 means a new sample is stored for channel i.
REQ-015 result_valid / result_ch / result_data  out  1/3/12  one-cycle pulse with the stored sample.
REQ-016 scan_done  out  1  one-cycle pulse when a full scan completes.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 timeout_err  out  1  sticky conversion-timeout flag.

Function
REQ-019 SHALL implement the states IDLE, START, ARM, WAIT, STORE and GAP.
REQ-020 IDLE SHALL latch ch_mask into scan_mask and go to START with the lowest set bit as the channel when enable = 1 and ch_mask != 0; otherwise it SHALL remain in IDLE.
REQ-021 START SHALL drive adc_start = 1 for exactly one cycle, with adc_ch already equal to the selected channel in that cycle.
REQ-022 ARM SHALL hold adc_start = 0 for one cycle, and adc_done SHALL be ignored in START and ARM (it is stale from the previous conversion).
REQ-023 WAIT SHALL sample adc_done each cycle; on adc_done = 1 it SHALL capture adc_data into ch_data[adc_ch] at that edge and go to STORE.
REQ-024 adc_ch SHALL remain stable from START until the next START.
REQ-025 STORE SHALL last one cycle with result_valid = 1, result_ch = adc_ch and result_data = the captured value, and SHALL set ch_fresh[adc_ch].
REQ-026 After STORE, the next channel SHALL be the next higher set bit of scan_mask (ascending, no wrap within a scan), entering START immediately; latency from STORE to the next adc_start SHALL be 1 clock.
REQ-027 If STORE handles the last channel, scan_done SHALL pulse in that same cycle and the FSM SHALL go to GAP, or to IDLE when GAP_CYCLES = 0.
REQ-028 GAP SHALL count GAP_CYCLES clocks and then go to IDLE.
REQ-029 A cleared enable SHALL not abort an in-flight conversion: the FSM SHALL finish WAIT and STORE, then go to IDLE without asserting scan_done.
REQ-030 ch_mask changes during a scan SHALL not affect the scan; they SHALL take effect at the next IDLE.
REQ-031 When fresh_clr[i] and a store to channel i occur in the same cycle, the set SHALL win.
REQ-032 When err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-033 The wait counter SHALL be 16 bits, clear on entry to WAIT, and saturate rather than wrap.

Reset
REQ-034 On reset the FSM SHALL go to IDLE and drive adc_start = 0, adc_ch = 0, ch_data = 0, ch_fresh = 0, result_valid = 0, result_ch = 0, result_data = 0, scan_done = 0, busy = 0 and timeout_err = 0.
REQ-035 Reset asserted mid-conversion SHALL take effect on the next edge; the first post-reset conversion SHALL start only from IDLE.

Configuration
REQ-036 With MDA_ADC_SEQ_TIMEOUT_EN defined, WAIT reaching TIMEOUT_CYCLES without adc_done SHALL set timeout_err, leave ch_data and ch_fresh unchanged, suppress result_valid, and continue as if STORE had completed (next channel, or scan_done).
REQ-037 Without MDA_ADC_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and err_clr SHALL be ignored.

Verification
REQ-038 Full scan: mask = 8'hFF with a controller model returning 12'h100+ch -> eight result_valid pulses for ch 0..7 in order, ch_data[ch] = 12'h100+ch, ch_fresh = 8'hFF, one scan_done.
REQ-039 Sparse mask and gap: mask = 8'b1000_0101, GAP_CYCLES = 10 -> conversions on ch 0, 2 and 7 only; the next scan's adc_start comes at least 11 clocks after scan_done.
REQ-040 Stale done: adc_done held high from the prior conversion, new conversion takes 400 clocks -> no STORE before the new done; the stored value is the new data.
REQ-041 Enable drop: enable cleared during WAIT on ch 3 of 8'hFF -> ch 3 is stored, no adc_start for ch 4, no scan_done, busy = 0.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES = 50): model never raises done on ch 1 -> timeout_err = 1 after 50 WAIT clocks, ch_fresh[1] = 0, scan continues on ch 2; err_clr then clears the flag.
REQ-043 Fresh collision: fresh_clr[5] = 1 in the STORE cycle of ch 5 -> ch_fresh[5] = 1.
